// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST vector sweeper.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic ORDER_BINARY = 1'b0;
    localparam logic ORDER_GRAY   = 1'b1;

    localparam int unsigned MAX_N_IN = 16;

    function automatic logic [MAX_N_IN-1:0] bin2gray(input logic [MAX_N_IN-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/bist_vec_gen.sv
// Vector index, hold counter and binary/Gray mapping for the BIST sweeper.
module bist_vec_gen
    import bist_pkg::*;
#(
    parameter int unsigned N_IN = 6,
    parameter int unsigned HOLD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            gray_mode,
    input  logic            run,
    output logic [N_IN-1:0] vec_out,
    output logic            sample_c,
    output logic            last_c
);

    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    logic [N_IN-1:0] idx_q;
    logic [N_IN-1:0] idx_inc;
    logic [HW-1:0]   hold_q;
    logic            order_q;

    assign idx_inc  = idx_q + N_IN'(1);
    assign sample_c = (hold_q == HOLD_LAST);
    assign last_c   = &idx_q;

    // The terminal vector never advances, so vec_out holds it after the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            hold_q  <= '0;
            order_q <= ORDER_BINARY;
            vec_out <= '0;
        end else if (load) begin
            idx_q   <= '0;
            hold_q  <= '0;
            order_q <= gray_mode;
            vec_out <= '0;
        end else if (run) begin
            if (sample_c) begin
                hold_q <= '0;
                if (!last_c) begin
                    idx_q   <= idx_inc;
                    vec_out <= (order_q == ORDER_GRAY)
                             ? N_IN'(bin2gray(MAX_N_IN'(idx_inc)))
                             : idx_inc;
                end
            end else begin
                hold_q <= hold_q + HW'(1);
            end
        end
    end

endmodule

// File: rtl/bist_vector_sweeper.sv
// Exhaustive-vector BIST sequencer: sweeps all inputs, compares DUT to golden, reports verdict.
module bist_vector_sweeper
    import bist_pkg::*;
#(
    parameter int unsigned N_IN = 6,
    parameter int unsigned HOLD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            gray_mode,
    input  logic            dut_y,
    input  logic            exp_y,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam int unsigned EW = N_IN + 1;

    state_e          state_q, state_d;
    logic            busy_d, done_d, pass_d, ffv_d;
    logic [EW-1:0]   err_d;
    logic [N_IN-1:0] ffvec_d;
    logic            load_c, run_c, sample_c, last_c, mismatch_c;

    assign load_c     = (state_q == IDLE) && start;
    assign run_c      = (state_q == RUN) && !abort;
    assign mismatch_c = dut_y ^ exp_y;

    bist_vec_gen #(
        .N_IN (N_IN),
        .HOLD (HOLD)
    ) u_vec_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .gray_mode (gray_mode),
        .run       (run_c),
        .vec_out   (vec_out),
        .sample_c  (sample_c),
        .last_c    (last_c)
    );

    // Next state and next result values; abort discards the same-cycle compare.
    always_comb begin
        state_d = state_q;
        busy_d  = busy;
        done_d  = 1'b0;
        pass_d  = pass;
        err_d   = err_count;
        ffvec_d = first_fail_vec;
        ffv_d   = first_fail_valid;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    ffvec_d = '0;
                    ffv_d   = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (sample_c) begin
                    if (mismatch_c) begin
                        err_d = err_count + EW'(1);
                        if (!first_fail_valid) begin
                            ffvec_d = vec_out;
                            ffv_d   = 1'b1;
                        end
                    end
                    if (last_c) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state_q          <= state_d;
            busy             <= busy_d;
            done             <= done_d;
            pass             <= pass_d;
            err_count        <= err_d;
            first_fail_vec   <= ffvec_d;
            first_fail_valid <= ffv_d;
        end
    end

endmodule
